// File: rtl/akp_ksi_pkg.sv
// Shared definitions for the KSI sequencer: state encoding and default unit latencies.
package akp_ksi_pkg;

   localparam int unsigned DEF_DIV_LAT  = 6;
   localparam int unsigned DEF_SUB_LAT  = 7;
   localparam int unsigned DEF_MULT_LAT = 5;
   localparam int unsigned DEF_ACC_LAT  = 3;

   // State encoding kept as plain constants so legacy netlists can decode the state bits.
   typedef logic [2:0] ksi_state_t;
   localparam ksi_state_t StIdle   = 3'd0;
   localparam ksi_state_t StAcc1   = 3'd1;
   localparam ksi_state_t StDrain1 = 3'd2;
   localparam ksi_state_t StAcc2   = 3'd3;
   localparam ksi_state_t StDrain2 = 3'd4;
   localparam ksi_state_t StFinal  = 3'd5;
   localparam ksi_state_t StDone   = 3'd6;

endpackage

// File: rtl/ksi_dly_line.sv
// One-bit delay line of DEPTH stages with synchronous clear.
module ksi_dly_line #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic clr_n,
   input  logic clr,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n)   sr_q <= '0;
            else if (clr) sr_q <= '0;
            else          sr_q <= din;
         end
      end else begin : g_many
         always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n)   sr_q <= '0;
            else if (clr) sr_q <= '0;
            else          sr_q <= {sr_q[DEPTH-2:0], din};
         end
      end
   endgenerate

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ksi_seq_ctrl.sv
// Two-pass (mean, then variance) KSI sequencer: drives FIFO reads, accumulator strobes and
// waits out the pipeline latencies of the FP datapath before flagging ksi_en.
module ksi_seq_ctrl
   import akp_ksi_pkg::*;
#(
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
   parameter int unsigned SUB_LAT  = DEF_SUB_LAT,
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned ACC_LAT  = DEF_ACC_LAT
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        work,
   input  logic        ink,
   input  logic [11:0] L_stroke,
   input  logic        fifo_empty,
   output logic        fifo_rd,
   output logic        pass2,
   output logic        acc_new,
   output logic        acc_en,
   output logic [11:0] L_stroke_1,
   output logic        busy,
   output logic        ksi_en,
   output logic        err_len
);

   localparam int unsigned D1 = 1;
   localparam int unsigned D2 = 1 + SUB_LAT + MULT_LAT;
   localparam logic [11:0] DRN1_LAST = 12'(D1 + ACC_LAT - 1);
   localparam logic [11:0] DRN2_LAST = 12'(D2 + ACC_LAT - 1);
   localparam logic [11:0] FIN_LAST  = 12'(2 * DIV_LAT + MULT_LAT + SUB_LAT - 1);

   ksi_state_t  state_q, state_d;
   logic [11:0] rd_cnt_q, rd_cnt_d, wt_cnt_q, wt_cnt_d, l1_q;
   logic        first_q, first_d, err_q;
   logic        start, len_zero, pass_start, dly_clr;
   logic        rd_p1, rd_p2, acc1_out, acc2_out;

   always_comb begin
      fifo_rd  = work && (state_q == StAcc1 || state_q == StAcc2) && !fifo_empty;
      pass2    = state_q inside {StAcc2, StDrain2, StFinal, StDone};
      busy     = (state_q != StIdle);
      ksi_en   = work && (state_q == StDone);
      acc_en   = work && (acc1_out || acc2_out);
      acc_new  = acc_en && first_q;
      len_zero = (L_stroke == 12'd0);
      start    = work && ink && (state_q == StIdle) && !len_zero;
      rd_p1    = fifo_rd && !pass2;
      rd_p2    = fifo_rd && pass2;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start) state_d = StAcc1;
         StAcc1:   if (fifo_rd && rd_cnt_q == l1_q - 12'd1) state_d = StDrain1;
         StDrain1: if (wt_cnt_q == DRN1_LAST) state_d = StAcc2;
         StAcc2:   if (fifo_rd && rd_cnt_q == l1_q - 12'd1) state_d = StDrain2;
         StDrain2: if (wt_cnt_q == DRN2_LAST) state_d = StFinal;
         StFinal:  if (wt_cnt_q == FIN_LAST) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      if (!work) state_d = StIdle;
   end

   // Both counters restart on every state change, so each pass and wait starts from zero.
   always_comb begin
      pass_start = (state_d != state_q) && (state_d == StAcc1 || state_d == StAcc2);
      dly_clr    = !work || pass_start;
      rd_cnt_d   = rd_cnt_q + {11'd0, fifo_rd};
      wt_cnt_d   = wt_cnt_q;
      if (state_q inside {StDrain1, StDrain2, StFinal}) wt_cnt_d = wt_cnt_q + 12'd1;
      if (state_d != state_q) begin
         rd_cnt_d = '0;
         wt_cnt_d = '0;
      end
      first_d = pass_start ? 1'b1 : (acc_en ? 1'b0 : first_q);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= StIdle;
         rd_cnt_q <= '0;
         wt_cnt_q <= '0;
         l1_q     <= '0;
         first_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_cnt_q <= rd_cnt_d;
         wt_cnt_q <= wt_cnt_d;
         first_q  <= first_d;
         err_q    <= work && ink && (state_q == StIdle) && len_zero;
         if (start) l1_q <= L_stroke;
      end
   end

   assign L_stroke_1 = l1_q;
   assign err_len    = err_q;

   ksi_dly_line #(.DEPTH(D1)) u_dly_p1 (
      .clk   (clk),
      .clr_n (clr_n),
      .clr   (dly_clr),
      .din   (rd_p1),
      .dout  (acc1_out)
   );

   ksi_dly_line #(.DEPTH(D2)) u_dly_p2 (
      .clk   (clk),
      .clr_n (clr_n),
      .clr   (dly_clr),
      .din   (rd_p2),
      .dout  (acc2_out)
   );

endmodule
